regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the single write port of the 32x32 register file among `NREQ` writeback requesters: pipeline writeback, multiply/divide completion, and the debug/program loader. Arbitration is round-robin with a valid/ready handshake per requester, and the winning write is registered onto the regfile's `ctrl_writeEnable`/`ctrl_writeReg`/`data_writeReg`. The block also keeps a 32-bit busy scoreboard of registers with outstanding writes, which decode uses for hazard stalls. It sits between the execute/writeback stage and `regfile`.

## Interface
Parameters:
- `NREQ`, 3: number of write requesters (2..8).
- `DW`, 32: data width.
- `AW`, 5: register address width (32 registers).

Ports:
- `clock`  in  1: single clock; all state changes on the rising edge.
- `ctrl_reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: requester i has a write pending.
- `req_reg`  in  NREQ*AW: destination register; requester i occupies bits [i*AW +: AW].
- `req_data`  in  NREQ*DW: write data; requester i occupies bits [i*DW +: DW].
- `req_ready`  out  NREQ: grant; a transfer occurs when `req_valid[i] && req_ready[i]` at the clock edge.
- `wb_hold`  in  1: suppresses all grants this cycle.
- `rsv_valid`  in  1: decode reserves a destination register.
- `rsv_reg`  in  AW: register being reserved.
- `ctrl_writeEnable`  out  1: registered write strobe to `regfile`.
- `ctrl_writeReg`  out  AW: registered write address.
- `data_writeReg`  out  DW: registered write data.
- `busy`  out  32: scoreboard; bit r=1 means a write to r is outstanding.

## Operation
- Grant is combinational, at most one-hot. With `wb_hold`=0, the first valid requester searching upward from `(last+1) mod NREQ` is granted. `req_ready` is low for every other requester and for all requesters while `wb_hold`=1.
- `last` updates to the granted index on every accepted transfer. It holds when there is no transfer.
- The accepted `req_reg`/`req_data` load into the output register:
  - `ctrl_writeEnable` is set to 1 only if `req_reg` != 0.
  - Writes to r0 are accepted (handshake completes) but never strobed.
- If no transfer occurs, `ctrl_writeEnable` is 0 next cycle. `ctrl_writeReg` and `data_writeReg` hold their last values.
- Scoreboard rules:
  - `rsv_valid` with `rsv_reg` != 0 sets `busy[rsv_reg]`. Reservations of r0 are ignored; `busy[0]` is always 0.
  - `busy[r]` clears on the edge ending a cycle in which `ctrl_writeEnable`=1 and `ctrl_writeReg`=r.
  - Set and clear of the same r in the same cycle: set wins (a new write is outstanding).
  - Reserving an already-busy register keeps it at 1. There is no counting; decode must not reserve a busy register.
- Requesters must hold `req_valid`, `req_reg` and `req_data` stable until accepted. The arbiter does not check this.

## Timing
- Reset (asynchronous, any time, including mid-transfer) forces:
  - `ctrl_writeEnable`=0, `ctrl_writeReg`=0, `data_writeReg`=0;
  - `busy`=0;
  - `last`=NREQ-1, so requester 0 has first priority.
  - Pending requests are not lost; they re-arbitrate after reset deasserts.
- While `ctrl_reset`=1, `req_ready`=0.
- Latency:
  - Handshake at edge T puts the write on the outputs during cycle T+1.
  - `regfile` captures at edge T+2.
  - `busy` clears at edge T+2, so a dependent read issued in cycle T+2 sees the new value.
- Throughput is one write per cycle. Under sustained requests from all NREQ requesters, each is granted exactly once per NREQ cycles.
- When a single requester is valid, it is granted every cycle with no bubbles.

## Test plan
- Reset, then drive req0 valid with reg=3, data=0xDEADBEEF. Required: ready0=1 in the same cycle; next cycle we=1, writeReg=3, data=0xDEADBEEF; the following cycle we=0.
- All 3 requesters valid continuously for 6 cycles. Required grant order 0,1,2,0,1,2; outputs track the same order one cycle later.
- req1 writes r0 with data=0x1234. Required: ready1=1, `ctrl_writeEnable` stays 0, `busy` unchanged.
- rsv_reg=7, then req2 writes r7 three cycles later. Required: `busy[7]` is 1 from the edge after reservation until the edge ending the we=1 cycle, then 0. Repeat with a same-cycle reserve of r7 while we=1 for r7: `busy[7]` must remain 1.
- `wb_hold`=1 for 2 cycles with req0 and req1 valid. Required: no ready and we=0 during the hold; after release, req0 is granted first.
- Assert `ctrl_reset` asynchronously (mid-cycle) while we=1 and `busy`=0x00000088. Required: we=0, writeReg=0, data=0 and `busy`=0 immediately; after release, the still-valid req1 is re-granted.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register file: round-robin grant among
// NREQ requesters, one registered write per cycle, plus a busy scoreboard
// that decode uses for hazard stalls.

// One scoreboard bit. A reservation beats a completing write, because the
// reservation stands for a newer write that is still in flight.
module regfile_wb_busy_bit (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic setEn,
  input  logic clrEn,
  output logic busyBit
);

  // Set has priority over clear.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset)  busyBit <= 1'b0;
    else if (setEn)  busyBit <= 1'b1;
    else if (clrEn)  busyBit <= 1'b0;
  end

endmodule

module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_reg,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               wb_hold,
  input  logic               rsv_valid,
  input  logic [AW-1:0]      rsv_reg,
  output logic               ctrl_writeEnable,
  output logic [AW-1:0]      ctrl_writeReg,
  output logic [DW-1:0]      data_writeReg,
  output logic [31:0]        busy
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  logic [IW-1:0] lastIdx;
  logic [IW-1:0] grantIdx;
  logic          xfer;
  logic [AW-1:0] selReg;
  logic [DW-1:0] selData;

  // Index of the requester 'off' positions after 'base', wrapping at NREQ.
  function automatic logic [IW-1:0] wrapIdx(input logic [IW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NREQ;
    return IW'(s);
  endfunction

  // Rotating-priority search starting just after the last winner; nothing
  // is granted while held or in reset, so pending requests simply wait.
  always_comb begin
    req_ready = '0;
    grantIdx  = lastIdx;
    xfer      = 1'b0;
    if (!wb_hold && !ctrl_reset) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!xfer && req_valid[wrapIdx(lastIdx, k)]) begin
          grantIdx = wrapIdx(lastIdx, k);
          xfer     = 1'b1;
        end
      end
    end
    if (xfer) req_ready[grantIdx] = 1'b1;
  end

  // Winner's payload; a grant always implies the winner is valid.
  always_comb begin
    selReg  = req_reg[grantIdx*AW +: AW];
    selData = req_data[grantIdx*DW +: DW];
  end

  // Register the accepted write; r0 writes complete the handshake but never
  // strobe, and address/data hold when idle.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      lastIdx          <= LAST_RST;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else if (xfer) begin
      lastIdx          <= grantIdx;
      ctrl_writeEnable <= (selReg != '0);
      ctrl_writeReg    <= selReg;
      data_writeReg    <= selData;
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

  // r0 is never outstanding.
  assign busy[0] = 1'b0;

  // Zero-extended compares keep registers beyond 2**AW from aliasing.
  genvar r;
  generate
    for (r = 1; r < 32; r++) begin : gBusy
      regfile_wb_busy_bit uBit (
        .clock     (clock),
        .ctrl_reset(ctrl_reset),
        .setEn     (rsv_valid && (32'(rsv_reg) == r)),
        .clrEn     (ctrl_writeEnable && (32'(ctrl_writeReg) == r)),
        .busyBit   (busy[r])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic               clock;
  logic               ctrl_reset;
  logic [NREQ-1:0]    vIn;
  logic [AW-1:0]      rIn [NREQ];
  logic [DW-1:0]      dIn [NREQ];
  logic [NREQ*AW-1:0] regBus;
  logic [NREQ*DW-1:0] dataBus;
  logic [NREQ-1:0]    req_ready;
  logic               wb_hold;
  logic               rsv_valid;
  logic [AW-1:0]      rsv_reg;
  logic               ctrl_writeEnable;
  logic [AW-1:0]      ctrl_writeReg;
  logic [DW-1:0]      data_writeReg;
  logic [31:0]        busy;

  int checks = 0;
  int failures = 0;

  always_comb begin
    regBus  = '0;
    dataBus = '0;
    for (int i = 0; i < NREQ; i++) begin
      regBus[i*AW +: AW]  = rIn[i];
      dataBus[i*DW +: DW] = dIn[i];
    end
  end

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clock           (clock),
    .ctrl_reset      (ctrl_reset),
    .req_valid       (vIn),
    .req_reg         (regBus),
    .req_data        (dataBus),
    .req_ready       (req_ready),
    .wb_hold         (wb_hold),
    .rsv_valid       (rsv_valid),
    .rsv_reg         (rsv_reg),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg   (ctrl_writeReg),
    .data_writeReg   (data_writeReg),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          mLast;
  bit          mWe;
  int          mReg;
  bit [31:0]   mData;
  bit [31:0]   mBusy;
  int          nLast;
  bit          nWe;
  int          nReg;
  bit [31:0]   nData;
  bit [31:0]   nBusy;

  always @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      mLast <= NREQ - 1; mWe <= 0; mReg <= 0; mData <= 0; mBusy <= 0;
    end else begin
      mLast <= nLast; mWe <= nWe; mReg <= nReg; mData <= nData; mBusy <= nBusy;
    end
  end

  // Compare against the model, then work out what the next edge must produce.
  always @(negedge clock) begin
    int g;
    bit [NREQ-1:0] expRdy;
    bit [31:0] b;
    g = -1;
    if (!ctrl_reset && !wb_hold)
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && vIn[(mLast + k) % NREQ]) g = (mLast + k) % NREQ;
    expRdy = '0;
    if (g >= 0) expRdy[g] = 1'b1;
    chk("m_ready", 64'(req_ready), 64'(expRdy));
    chk("m_we",    64'(ctrl_writeEnable), 64'(mWe));
    chk("m_reg",   64'(ctrl_writeReg), 64'(mReg));
    chk("m_data",  64'(data_writeReg), 64'(mData));
    chk("m_busy",  64'(busy), 64'(mBusy));
    b = mBusy;
    if (mWe) b[mReg] = 1'b0;
    if (rsv_valid && rsv_reg != 0) b[rsv_reg] = 1'b1;
    nBusy = b;
    nLast = mLast; nReg = mReg; nData = mData; nWe = 0;
    if (g >= 0) begin
      nLast = g; nReg = int'(rIn[g]); nData = dIn[g]; nWe = (rIn[g] != 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic atNeg();
    @(negedge clock); #1;
  endtask

  task automatic idleInputs();
    vIn = '0; wb_hold = 0; rsv_valid = 0; rsv_reg = '0;
    for (int i = 0; i < NREQ; i++) begin rIn[i] = '0; dIn[i] = '0; end
  endtask

  task automatic pulseReset();
    cyc(); ctrl_reset = 1'b1;
    cyc(); ctrl_reset = 1'b0;
  endtask

  initial begin
    bit [NREQ-1:0] acc;
    bit rstPending;
    ctrl_reset = 1'b0;
    idleInputs();
    #1 ctrl_reset = 1'b1;
    atNeg();
    chk("rst_we", 64'(ctrl_writeEnable), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    cyc(); ctrl_reset = 1'b0;

    // single write to r3
    vIn[0] = 1; rIn[0] = 3; dIn[0] = 32'hDEADBEEF;
    atNeg(); chk("t1_ready", 64'(req_ready), 64'b001);
    cyc(); vIn[0] = 0;
    atNeg();
    chk("t1_we", 64'(ctrl_writeEnable), 64'd1);
    chk("t1_reg", 64'(ctrl_writeReg), 64'd3);
    chk("t1_data", 64'(data_writeReg), 64'hDEADBEEF);
    cyc(); atNeg(); chk("t1_we_off", 64'(ctrl_writeEnable), 64'd0);

    // all three valid: round-robin 0,1,2,0,1,2
    pulseReset();
    for (int i = 0; i < NREQ; i++) begin rIn[i] = AW'(10 + i); dIn[i] = 32'hA0 + i; end
    vIn = '1;
    for (int k = 0; k < 6; k++) begin
      atNeg();
      chk("rr_ready", 64'(req_ready), 64'(1 << (k % 3)));
      if (k > 0) chk("rr_reg", 64'(ctrl_writeReg), 64'(10 + (k - 1) % 3));
      cyc();
    end
    vIn = '0;
    atNeg(); chk("rr_last_reg", 64'(ctrl_writeReg), 64'd12);

    // write to r0: accepted, never strobed
    cyc(); vIn[1] = 1; rIn[1] = 0; dIn[1] = 32'h1234;
    atNeg(); chk("r0_ready", 64'(req_ready), 64'b010);
    cyc(); vIn[1] = 0;
    atNeg();
    chk("r0_we", 64'(ctrl_writeEnable), 64'd0);
    chk("r0_data", 64'(data_writeReg), 64'h1234);
    chk("r0_busy", 64'(busy), 64'd0);

    // reserve r7, write it three cycles later
    cyc(); rsv_valid = 1; rsv_reg = 7;
    atNeg(); chk("sb_pre", 64'(busy), 64'd0);
    cyc(); rsv_valid = 0;
    atNeg(); chk("sb_set", 64'(busy), 64'h80);
    cyc(); cyc(); vIn[2] = 1; rIn[2] = 7; dIn[2] = 32'h77;
    atNeg(); chk("sb_ready", 64'(req_ready), 64'b100);
    cyc(); vIn[2] = 0;
    atNeg();
    chk("sb_we", 64'(ctrl_writeEnable), 64'd1);
    chk("sb_hold1", 64'(busy), 64'h80);
    cyc(); atNeg(); chk("sb_clr", 64'(busy), 64'h0);
    // same-cycle reserve and completing write: set wins
    cyc(); rsv_valid = 1; rsv_reg = 7;
    cyc(); rsv_valid = 0; vIn[2] = 1;
    atNeg(); chk("sw_ready", 64'(req_ready), 64'b100);
    cyc(); vIn[2] = 0; rsv_valid = 1; rsv_reg = 7;
    atNeg();
    chk("sw_we", 64'(ctrl_writeEnable), 64'd1);
    cyc(); rsv_valid = 0;
    atNeg(); chk("sw_busy", 64'(busy), 64'h80);

    // hold for two cycles
    wb_hold = 1; vIn[0] = 1; vIn[1] = 1; rIn[0] = 1; rIn[1] = 2;
    for (int k = 0; k < 2; k++) begin
      atNeg();
      chk("hold_ready", 64'(req_ready), 64'd0);
      chk("hold_we", 64'(ctrl_writeEnable), 64'd0);
      cyc();
    end
    wb_hold = 0;
    atNeg(); chk("hold_rel", 64'(req_ready), 64'b001);
    cyc(); vIn[0] = 0;
    atNeg(); chk("hold_next", 64'(req_ready), 64'b010);
    cyc(); vIn[1] = 0;

    // async reset mid-cycle while a write is on the outputs
    rsv_valid = 1; rsv_reg = 3;
    cyc(); rsv_valid = 0;
    vIn[0] = 1; rIn[0] = 5; dIn[0] = 32'h55;
    vIn[1] = 1; rIn[1] = 9; dIn[1] = 32'h99;
    atNeg(); chk("ar_ready0", 64'(req_ready), 64'b001);
    cyc(); vIn[0] = 0;
    #1;
    chk("ar_we_pre", 64'(ctrl_writeEnable), 64'd1);
    chk("ar_busy_pre", 64'(busy), 64'h88);
    #1 ctrl_reset = 1'b1;
    #1;
    chk("ar_we", 64'(ctrl_writeEnable), 64'd0);
    chk("ar_reg", 64'(ctrl_writeReg), 64'd0);
    chk("ar_data", 64'(data_writeReg), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_ready", 64'(req_ready), 64'd0);
    cyc(); ctrl_reset = 1'b0;
    atNeg(); chk("ar_regrant", 64'(req_ready), 64'b010);
    cyc(); vIn[1] = 0;
    atNeg();
    chk("ar_out_reg", 64'(ctrl_writeReg), 64'd9);
    chk("ar_out_data", 64'(data_writeReg), 64'h99);

    // randomized traffic; requests stay stable until accepted
    acc = '0;
    rstPending = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (rstPending) begin ctrl_reset = 1'b0; rstPending = 0; end
      for (int i = 0; i < NREQ; i++) begin
        if (!vIn[i] || acc[i]) begin
          vIn[i] = ($urandom_range(0, 2) != 0);
          rIn[i] = AW'($urandom_range(0, 31));
          dIn[i] = $urandom;
        end
      end
      wb_hold   = ($urandom_range(0, 7) == 0);
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_reg   = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 299) == 0) begin
        #2 ctrl_reset = 1'b1;
        rstPending = 1;
      end
      atNeg();
      acc = vIn & req_ready;
    end

    cyc(); ctrl_reset = 1'b0; idleInputs();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
